// File: rtl/rotl_arb_pkg.sv
// Shared constants, types and helpers for the round-robin rotate-left arbiter.
package rotl_arb_pkg;

  localparam int unsigned DEF_N   = 4;
  localparam int unsigned DEF_REQ = 4;
  localparam int unsigned DEF_W   = 1 << DEF_N;
  localparam int unsigned DEF_IDW = $clog2(DEF_REQ);

  typedef logic [DEF_W-1:0]   word_t;
  typedef logic [DEF_N-1:0]   amt_t;
  typedef logic [DEF_IDW-1:0] id_t;

  // Next round-robin pointer; stays inside 0..req-1 for any requester count.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned req);
    return (ptr + 1 >= req) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rotl_core.sv
// Combinational W-bit rotate-left built as a log2 network of fixed power-of-two rotates.
module rotl_core #(
  parameter int unsigned N = 4
) (
  input  logic [(1<<N)-1:0] word,
  input  logic [N-1:0]      amt,
  output logic [(1<<N)-1:0] rot
);

  localparam int unsigned W = 1 << N;

  logic [N:0][W-1:0] stage;

  assign stage[0] = word;

  // Stage s rotates by 2**s when amount bit s is set.
  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int unsigned SH = 1 << s;
    assign stage[s+1] = amt[s] ? ((stage[s] << SH) | (stage[s] >> (W - SH))) : stage[s];
  end

  assign rot = stage[N];

endmodule

// File: rtl/rotl_rr_arbiter.sv
// Round-robin arbiter sharing one rotate-left datapath among REQ requesters,
// with a single registered result slot (1-cycle latency, full throughput).
module rotl_rr_arbiter
  import rotl_arb_pkg::*;
#(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned REQ = DEF_REQ,
  parameter int unsigned IDW = $clog2(REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [REQ-1:0]             req_valid,
  output logic [REQ-1:0]             req_ready,
  input  logic [REQ-1:0][(1<<N)-1:0] req_data,
  input  logic [REQ-1:0][N-1:0]      req_amt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [(1<<N)-1:0]          out_data,
  output logic [IDW-1:0]             out_id,
  output logic [IDW-1:0]             grant_ptr
);

  localparam int unsigned W = 1 << N;

  logic           accept;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] scan_idx;
  int unsigned    scan;
  logic [W-1:0]   win_data;
  logic [N-1:0]   win_amt;
  logic [W-1:0]   win_rot;
  logic           xfer;

  // The result slot can take a new word when empty or draining this cycle.
  assign accept = (!out_valid || out_ready) && !flush && rst_n;

  // Ascending scan from the priority pointer, wrapping REQ-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < REQ; i++) begin
      scan = 32'(grant_ptr) + i;
      if (scan >= REQ) scan = scan - REQ;
      scan_idx = IDW'(scan);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept && win_found) req_ready[win_idx] = 1'b1;
  end

  assign xfer     = accept && win_found;
  assign win_data = req_data[win_idx];
  assign win_amt  = req_amt[win_idx];

  rotl_core #(.N(N)) u_core (
    .word (win_data),
    .amt  (win_amt),
    .rot  (win_rot)
  );

  // Result slot and pointer; flush overrides any grant or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      grant_ptr <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= win_rot;
      out_id    <= win_idx;
      grant_ptr <= IDW'(rr_next(32'(win_idx), REQ));
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rotl_rr_arbiter.md
Name: rotl_rr_arbiter

Overview:
- Shares one rotate-left datapath (16-bit word at N=4) between REQ independent requesters.
- Round-robin arbitration with valid/ready handshakes on every requester port and on the single result port.
- The result is registered: 1-cycle latency, 1 result/cycle sustained throughput.
- Sits between the operand sources and the downstream consumer of rotated words.

Parameters:
- N, 4, log2 of data width; data width W = 2**N, rotate amount is N bits.
- REQ, 4, number of requesters, 2..16.
- IDW, $clog2(REQ), width of the requester index carried with each result.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; clears the result register and blocks grants this cycle.
- req_valid  in  REQ  per-requester operand valid.
- req_ready  out  REQ  per-requester accept; one-hot or zero.
- req_data  in  REQ x W (packed [REQ-1:0][W-1:0])  operands.
- req_amt  in  REQ x N (packed [REQ-1:0][N-1:0])  rotate-left amounts.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accept.
- out_data  out  W  rotated word.
- out_id  out  IDW  index of the requester that produced out_data.
- grant_ptr  out  IDW  current round-robin priority pointer (debug/observability).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_id=0, grant_ptr=0.
  - req_ready=0 while reset is asserted.
  - A result pending at reset is discarded.
- accept = (!out_valid || out_ready) && !flush.
- Arbitration (combinational):
  - Scan req_valid starting at index grant_ptr, ascending, wrapping REQ-1 -> 0.
  - The first set bit is the winner g.
  - If accept and a winner exists, req_ready[g]=1; all other req_ready bits are 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer, at the clock edge when req_valid[g] && req_ready[g]:
  - out_data <= rotl(req_data[g], req_amt[g]).
  - out_id <= g; out_valid <= 1.
  - grant_ptr <= (g+1) mod REQ.
- No transfer, out_valid && out_ready: out_valid <= 0. out_data and out_id keep their last values.
- Stall, out_valid && !out_ready:
  - out_data, out_id, out_valid and grant_ptr are held stable.
  - All req_ready bits are 0.
- Simultaneous drain and fill (out_valid && out_ready with a new grant): the register is reloaded, out_valid stays 1, no bubble.
- flush=1: out_valid <= 0 next edge; no grant this cycle; grant_ptr unchanged. Flush has priority over every other event.
- Rotate arithmetic:
  - rotl(x,k) = {x[W-1-k:0], x[W-1:W-k]} for k>0; rotl(x,0)=x.
  - k ranges 0..W-1; there is no modulo beyond N bits.
  - Pure bit permutation: no carry, no sign handling.
- grant_ptr wrap: g=REQ-1 gives grant_ptr=0. For non-power-of-two REQ, the pointer never takes values >= REQ.
- A requester that holds req_valid receives a grant within REQ accepting cycles (starvation-free).
- Requesters must hold req_data/req_amt stable while req_valid && !req_ready. The arbiter does not latch operands before grant.

Decomposition:
- Package rotl_arb_pkg:
  - default N, REQ constants.
  - function rr_next(ptr, REQ).
  - typedefs word_t (W bits), amt_t (N bits), id_t (IDW bits).
- Sub-module rotl_core: purely combinational W-bit rotate-left, inputs word and amt, output word.
  - Implemented as a log2 stage mux network (N stages of conditional 2^s rotate), not a variable-bound loop.
  - Instantiated once, fed from the winner's mux.

Test Plan:
- Reset mid-operation: load req0 data=16'h8001 amt=1, assert rst_n=0 before out_ready -> out_valid=0, out_data=0, grant_ptr=0 immediately (asynchronous).
- Single requester: req2 data=16'h8001 amt=1, out_ready=1 -> one cycle later out_valid=1, out_data=16'h0003, out_id=2, grant_ptr=3. Also cover amt=0 -> 16'hABCD unchanged, and amt=15 on 16'h0001 -> 16'h8000.
- All four valid continuously with out_ready=1 -> out_id sequence 0,1,2,3,0,... and out_valid=1 every cycle, no bubbles.
- Backpressure: hold out_ready=0 for 3 cycles with req1 valid -> out_data/out_id stable, req_ready=0 throughout. On out_ready=1, drain and refill happen in the same cycle.
- Wrap and fairness: grant_ptr=3 with req1 and req3 valid -> req3 granted first, then req1; grant_ptr ends at 2.
- Flush with req0 valid and out_valid=1 -> next cycle out_valid=0, req_ready stays 0 that cycle, grant_ptr unchanged.
